// File: rtl/fix_unsigned_pipeline_div_if.sv
// Operand/result bundle for fix_unsigned_pipeline_div.
// div_by_zero exists only when DIV_ZERO_FLAG_EN is defined.
interface fix_unsigned_pipeline_div_if #(
    parameter int WIDTH_dividend = 16,
    parameter int WIDTH_divisor  = 16
);
    logic                      valid;
    logic [WIDTH_dividend-1:0] dividend;
    logic [WIDTH_divisor-1:0]  divisor;
    logic                      ready;
    logic [WIDTH_dividend-1:0] quotient;
    logic [WIDTH_divisor-1:0]  remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic                      div_by_zero;

    modport master (output valid, dividend, divisor,
                    input  ready, quotient, remainder, div_by_zero);
    modport slave  (input  valid, dividend, divisor,
                    output ready, quotient, remainder, div_by_zero);
`else
    modport master (output valid, dividend, divisor,
                    input  ready, quotient, remainder);
    modport slave  (input  valid, dividend, divisor,
                    output ready, quotient, remainder);
`endif
endinterface

// File: rtl/fix_unsigned_pipeline_div.sv
// Fully pipelined restoring divider: one quotient bit per stage, MSB first.
// Optional macro DIV_ZERO_FLAG_EN adds a pipelined divide-by-zero flag.
module fix_unsigned_pipeline_div #(
    parameter int WIDTH_dividend = 16,
    parameter int WIDTH_divisor  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    fix_unsigned_pipeline_div_if.slave    bus
);
    localparam int WN = WIDTH_dividend;
    localparam int WD = WIDTH_divisor;

    // Returns {quotient bit, next partial remainder}.
    function automatic logic [WD:0] restore_step(
        input logic [WD-1:0] rem_in,
        input logic          bit_in,
        input logic [WD-1:0] dsr
    );
        logic [WD:0] partial;
        logic [WD:0] dsr_ext;
        logic        ge;
        partial = {rem_in, bit_in};
        dsr_ext = {1'b0, dsr};
        ge      = (partial >= dsr_ext);
        restore_step = ge ? {1'b1, WD'(partial - dsr_ext)} : {1'b0, partial[WD-1:0]};
    endfunction

    for (genvar k = 0; k < WN; k++) begin : g_stage
        logic          w_vld_in;
        logic [WN-1:0] w_dvd_in;
        logic [WD-1:0] w_dsr_in;
        logic [WN-1:0] w_quo_in;
        logic [WD-1:0] w_rem_in;
        logic [WD:0]   w_step;

        logic          r_vld_p;
        logic [WN-1:0] r_quo_p;
        logic [WD-1:0] r_rem_p;
`ifdef DIV_ZERO_FLAG_EN
        logic          w_dz_in;
        logic          r_dz_p;
`endif

        if (k == 0) begin : g_src
            assign w_vld_in = bus.valid;
            assign w_dvd_in = bus.dividend;
            assign w_dsr_in = bus.divisor;
            assign w_quo_in = '0;
            assign w_rem_in = '0;
`ifdef DIV_ZERO_FLAG_EN
            assign w_dz_in  = (bus.divisor == '0);
`endif
        end else begin : g_src
            assign w_vld_in = g_stage[k-1].r_vld_p;
            assign w_dvd_in = g_stage[k-1].g_carry.r_dvd_p;
            assign w_dsr_in = g_stage[k-1].g_carry.r_dsr_p;
            assign w_quo_in = g_stage[k-1].r_quo_p;
            assign w_rem_in = g_stage[k-1].r_rem_p;
`ifdef DIV_ZERO_FLAG_EN
            assign w_dz_in  = g_stage[k-1].r_dz_p;
`endif
        end

        assign w_step = restore_step(w_rem_in, w_dvd_in[WN-1], w_dsr_in);

        // Stage k boundary: valid always advances, data loads only on valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld_p <= 1'b0;
                r_quo_p <= '0;
                r_rem_p <= '0;
`ifdef DIV_ZERO_FLAG_EN
                r_dz_p  <= 1'b0;
`endif
            end else begin
                r_vld_p <= w_vld_in;
                if (w_vld_in) begin
                    r_quo_p <= w_quo_in | (WN'(w_step[WD]) << (WN-1-k));
                    r_rem_p <= w_step[WD-1:0];
`ifdef DIV_ZERO_FLAG_EN
                    r_dz_p  <= w_dz_in;
`endif
                end
            end
        end

        // The last stage has no successor, so operands stop one stage early.
        if (k < WN-1) begin : g_carry
            logic [WN-1:0] r_dvd_p;
            logic [WD-1:0] r_dsr_p;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dvd_p <= '0;
                    r_dsr_p <= '0;
                end else if (w_vld_in) begin
                    r_dvd_p <= w_dvd_in << 1;
                    r_dsr_p <= w_dsr_in;
                end
            end
        end
    end

    assign bus.ready    = g_stage[WN-1].r_vld_p;
    assign bus.quotient = g_stage[WN-1].r_quo_p;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.remainder   = g_stage[WN-1].r_dz_p ? '0 : g_stage[WN-1].r_rem_p;
    assign bus.div_by_zero = g_stage[WN-1].r_dz_p;
`else
    assign bus.remainder   = g_stage[WN-1].r_rem_p;
`endif

endmodule

// File: tb/tb_fix_unsigned_pipeline_div.sv
// Randomized bench for fix_unsigned_pipeline_div against a queue-based arithmetic model.
module tb_fix_unsigned_pipeline_div;
    localparam int WN = 16;
    localparam int WD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fix_unsigned_pipeline_div_if #(.WIDTH_dividend(WN), .WIDTH_divisor(WD)) bus ();

    fix_unsigned_pipeline_div #(.WIDTH_dividend(WN), .WIDTH_divisor(WD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WN-1:0] a;
        logic [WD-1:0] b;
        int            acc;
    } op_t;

    op_t           exp_q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            n_vld = 0;
    int            n_rdy = 0;
    logic [WN-1:0] last_q;
    logic [WD-1:0] last_r;
    logic          last_dz;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic observe();
        op_t           o;
        logic [WN-1:0] eq;
        logic [WD-1:0] er;
        logic          edz;
        if (bus.ready === 1'b1) begin
            n_rdy++;
            if (exp_q.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                o = exp_q.pop_front();
                if (o.b == 0) begin
                    eq  = '1;
                    edz = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    er  = '0;
`else
                    er  = WD'(o.a);
`endif
                end else begin
                    eq  = WN'(int'(o.a) / int'(o.b));
                    er  = WD'(int'(o.a) % int'(o.b));
                    edz = 1'b0;
                    check("identity",
                          ((longint'(bus.quotient) * longint'(o.b) + longint'(bus.remainder)
                            == longint'(o.a)) && (bus.remainder < o.b)), 1);
                end
                check("quotient", bus.quotient, eq);
                check("remainder", bus.remainder, er);
                check("latency", cyc - o.acc, WN);
`ifdef DIV_ZERO_FLAG_EN
                check("div_by_zero", bus.div_by_zero, edz);
                last_dz = bus.div_by_zero;
`else
                last_dz = edz;
`endif
                last_q = bus.quotient;
                last_r = bus.remainder;
            end
        end else begin
            check("ready_low", bus.ready, 0);
            check("hold_quotient", bus.quotient, last_q);
            check("hold_remainder", bus.remainder, last_r);
`ifdef DIV_ZERO_FLAG_EN
            check("hold_div_by_zero", bus.div_by_zero, last_dz);
`endif
        end
    endtask

    task automatic step(input logic v, input logic [WN-1:0] a, input logic [WD-1:0] b);
        op_t o;
        bus.valid    = v;
        bus.dividend = a;
        bus.divisor  = b;
        if (v) begin
            o.a = a; o.b = b; o.acc = cyc;
            exp_q.push_back(o);
            n_vld++;
        end
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic drain();
        repeat (WN + 2) step(1'b0, '0, '0);
    endtask

    logic [WN-1:0] vec_a [4] = '{16'hFFFF, 16'd5, 16'd0, 16'h8000};
    logic [WD-1:0] vec_b [4] = '{16'd1,    16'd9, 16'd3, 16'h0100};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WN-1:0] a;
        logic [WD-1:0] b;
        rst          = 1'b1;
        bus.valid    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        last_q = '0; last_r = '0; last_dz = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.ready, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst_div_by_zero", bus.div_by_zero, 0);
`endif
        rst = 1'b0;

        // Single operation 100 / 7.
        step(1'b1, 16'd100, 16'd7);
        drain();
        check("single_q14", last_q, 14);
        check("single_r2", last_r, 2);

        // Sixteen back-to-back operations, directed head then random tail.
        for (int i = 0; i < 16; i++) begin
            if (i < 4) step(1'b1, vec_a[i], vec_b[i]);
            else       step(1'b1, WN'($urandom), WD'($urandom_range(1, 16'hFFFF)));
        end
        drain();

        // Divide by zero.
        step(1'b1, 16'h1234, 16'd0);
        drain();

        // Reset pulse mid-clock with three operations in flight.
        step(1'b1, 16'd1000, 16'd3);
        step(1'b1, 16'd2000, 16'd7);
        step(1'b1, 16'd3000, 16'd11);
        step(1'b0, '0, '0);
        #2 rst = 1'b1;
        #1;
        check("rst_imm_ready", bus.ready, 0);
        check("rst_imm_quotient", bus.quotient, 0);
        check("rst_imm_remainder", bus.remainder, 0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst_imm_div_by_zero", bus.div_by_zero, 0);
`endif
        n_vld -= exp_q.size();
        exp_q.delete();
        last_q = '0; last_r = '0; last_dz = 1'b0;
        @(negedge clk);
        cyc++;
        // Presented while rst is still high; sampled on the first edge after release.
        step_hold_during_reset();
        drain();
        check("post_rst_q10", last_q, 10);
        check("post_rst_r0", last_r, 0);

        // Random operands with random gaps in valid.
        for (int i = 0; i < 10000; ) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, WN'($urandom), WD'($urandom));
            end else begin
                case ($urandom_range(0, 4))
                    0: a = '0;
                    1: a = '1;
                    default: a = WN'($urandom);
                endcase
                case ($urandom_range(0, 3))
                    0: b = WD'($urandom_range(1, 15));
                    1: b = '1;
                    default: b = WD'($urandom_range(1, 16'hFFFF));
                endcase
                step(1'b1, a, b);
                i++;
            end
        end
        drain();

        check("ready_count", n_rdy, n_vld);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    task automatic step_hold_during_reset();
        op_t o;
        bus.valid    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        o.a = 16'd50; o.b = 16'd5; o.acc = cyc;
        exp_q.push_back(o);
        n_vld++;
        #2 rst = 1'b0;
        @(negedge clk);
        cyc++;
        observe();
    endtask

endmodule

// File: doc/fix_unsigned_pipeline_div.md
FIX_UNSIGNED_PIPELINE_DIV -- requirements
Module: fix_unsigned_pipeline_div

Interface
REQ-001 SHALL have parameter WIDTH_dividend, default 16, dividend and quotient width (>=2).
REQ-002 SHALL have parameter WIDTH_divisor, default 16, divisor and remainder width (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid  input  1  operands valid this cycle.
REQ-006 SHALL have port dividend  input  WIDTH_dividend  unsigned numerator.
REQ-007 SHALL have port divisor  input  WIDTH_divisor  unsigned denominator.
REQ-008 SHALL have port ready  output  1  quotient/remainder valid this cycle.
REQ-009 SHALL have port quotient  output  WIDTH_dividend  unsigned floor(dividend/divisor).
REQ-010 SHALL have port remainder  output  WIDTH_divisor  unsigned dividend mod divisor.
REQ-011 SHALL have port div_by_zero  output  1  result came from divisor==0 (present only with DIV_ZERO_FLAG_EN).

Function
REQ-012 SHALL be a restoring divider of WIDTH_dividend registered stages, one quotient bit per stage, MSB first.
REQ-013 Stage k SHALL compute partial = {rem_in, dividend bit (WIDTH_dividend-1-k)} in WIDTH_divisor+1 bits; if partial >= divisor: rem_out = partial - divisor, q bit 1; else rem_out = partial, q bit 0.
REQ-014 Each stage SHALL carry divisor, remaining dividend bits, partial quotient, partial remainder and one valid bit to the next stage.
REQ-015 Stage valid bit SHALL update every cycle from the previous stage's valid; stage data registers SHALL load only when the incoming valid is 1, otherwise hold.
REQ-016 Latency SHALL be exactly WIDTH_dividend cycles: operands sampled at edge N give ready=1 with result after edge N+WIDTH_dividend-1 (i.e. visible during cycle N+WIDTH_dividend).
REQ-017 Throughput SHALL be one operation per cycle; no backpressure, no input stall, no result dropped or reordered.
REQ-018 ready SHALL be high for exactly one cycle per accepted operation; back-to-back valids SHALL give back-to-back ready.
REQ-019 When ready=0, quotient and remainder SHALL hold their last values.
REQ-020 Results SHALL be exact for all operand pairs with divisor != 0, including dividend < divisor (quotient 0, remainder dividend) and dividend == 0.
REQ-021 divisor==0 SHALL yield quotient all ones and remainder = dividend mod 2^WIDTH_divisor, the natural restoring result.
REQ-022 Gaps in valid SHALL leave in-flight operations unaffected.

Reset
REQ-023 rst=1 SHALL asynchronously clear all stage valid bits and data registers to 0, independent of clk.
REQ-024 During and after reset, ready, quotient, remainder (and div_by_zero) SHALL be 0 until the first post-reset result.
REQ-025 Reset mid-operation SHALL discard all in-flight operations; none SHALL produce ready after rst deasserts.
REQ-026 valid sampled on the first edge after rst falls SHALL be accepted normally.

Configuration
REQ-027 Macro DIV_ZERO_FLAG_EN SHALL, when defined, add port div_by_zero and a per-stage flag pipelined with valid; flag=1 forces quotient all ones and remainder 0 at output.
REQ-028 Without DIV_ZERO_FLAG_EN, port div_by_zero and its registers SHALL not exist and divisor==0 behaves per REQ-021.

Verification
REQ-029 Defaults, single op dividend=100 divisor=7 at edge 0 -> ready=1 in cycle 16 only, quotient=14, remainder=2.
REQ-030 16 consecutive valids with (dividend,divisor)=(0xFFFF,1),(5,9),(0,3),(0x8000,0x0100),... -> 16 consecutive ready cycles, in order: (0xFFFF,0),(0,5),(0,0),(0x0080,0),...
REQ-031 Divisor 0, dividend 0x1234: without macro -> quotient 0xFFFF, remainder 0x1234; with DIV_ZERO_FLAG_EN -> quotient 0xFFFF, remainder 0, div_by_zero=1.
REQ-032 Three ops in flight, rst pulsed for 1 cycle mid-clock -> outputs 0 immediately, no ready afterwards; new op 50/5 post-reset -> quotient 10, remainder 0 after 16 cycles.
REQ-033 Random valid gaps, 10000 random operand pairs with divisor != 0 -> every result matches reference model (q*d+r==dividend, r<d) in order, ready count equals valid count.
